nv_nvdla_sdp_rdma_unpack_n: RTL and testbench
=============================================

NV_NVDLA_SDP_RDMA_UNPACK_N -- requirements
Module: nv_nvdla_sdp_rdma_unpack_n

Interface
REQ-001 SHALL have parameter ATOM_W, default 256: bits per atom.
REQ-002 SHALL have parameter IN_ATOMS, default 1: atoms per input beat; legal range 1..OUT_ATOMS.
REQ-003 SHALL have parameter OUT_ATOMS, default 4: atoms per output beat; legal range >=2.
REQ-004 SHALL have port nvdla_core_clk, input, 1 bit: the single clock.
REQ-005 SHALL have port nvdla_core_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have inputs inp_pvld (1 bit) and inp_end (1 bit, last beat of surface), and output inp_prdy (1 bit).
REQ-007 SHALL have inputs inp_data (IN_ATOMS*ATOM_W bits) and inp_mask (IN_ATOMS bits): valid atoms, LSB-contiguous.
REQ-008 SHALL have outputs out_pvld (1 bit), out_data (OUT_ATOMS*ATOM_W bits), out_mask (OUT_ATOMS bits) and out_end (1 bit), and input out_prdy (1 bit).

Function
REQ-009 SHALL take n = popcount(inp_mask) atoms from lanes 0..n-1 of each accepted beat and place them at accumulator lanes cnt..cnt+n-1, with no beat alignment required.
REQ-010 SHALL hold cnt in $clog2(OUT_ATOMS)+1 bits, range 0..OUT_ATOMS-1 between beats.
REQ-011 SHALL implement states ACC and FLUSH.
REQ-012 SHALL drive inp_prdy = (state==ACC) & (!out_pvld | out_prdy).
REQ-013 SHALL, on acceptance with cnt+n >= OUT_ATOMS, load the output register with the low OUT_ATOMS combined atoms, set out_mask to all-ones, move the remaining cnt+n-OUT_ATOMS atoms to lanes 0.. of the accumulator, and set cnt to that remainder.
REQ-014 SHALL, on acceptance with cnt+n < OUT_ATOMS and inp_end=0, update only the accumulator and cnt, with out_pvld unaffected except by out_prdy.
REQ-015 SHALL, on acceptance with inp_end=1 and no spill, emit the accumulated atoms with out_mask = thermometer(cnt+n), out_end=1, and set cnt to 0.
REQ-016 SHALL, on acceptance with inp_end=1, cnt+n > OUT_ATOMS, emit the full beat with out_end=0 and enter FLUSH.
REQ-017 SHALL, in FLUSH, when (!out_pvld | out_prdy), emit the remainder with a thermometer mask and out_end=1, set cnt to 0, and return to ACC.
REQ-018 SHALL, on inp_end=1 with cnt+n==0, emit a beat with out_mask=0 and out_end=1.
REQ-019 SHALL, on inp_end=1 with cnt+n==OUT_ATOMS exactly, emit one beat with mask all-ones and out_end=1, and not enter FLUSH.
REQ-020 SHALL register all outputs: a completing accept in cycle N gives out_pvld=1 in cycle N+1.
REQ-021 SHALL hold out_data, out_mask and out_end stable while out_pvld & !out_prdy.
REQ-022 SHALL clear out_pvld after out_prdy when no new beat is loaded in the same cycle; a simultaneous out accept and load SHALL keep out_pvld=1 with the new content.
REQ-023 SHALL leave lanes of out_data with a mask bit of 0 as don't-care.
REQ-024 SHALL flag a non-contiguous inp_mask on an accepted beat through an assertion; the datapath SHALL still use the popcount.

Reset
REQ-025 SHALL, on nvdla_core_rst=1 at a clock edge, set out_pvld=0, out_mask=0, out_end=0, cnt=0 and state ACC, discarding any partial pack or pending FLUSH.
REQ-026 SHALL NOT reset out_data or accumulator data; the bench checks them only when out_pvld=1.
REQ-027 SHALL drive inp_prdy=1 in the first cycle after reset deasserts.

Structure
REQ-028 SHALL define the state enum, the popcount and thermometer functions, and the default ATOM_W in package nv_nvdla_sdp_rdma_unpack_pkg.
REQ-029 SHALL implement atom placement (shift by cnt, split into out/remainder) as sub-module nv_nvdla_sdp_rdma_atom_place, combinational, parametrised identically.

Verification (ATOM_W=8, IN_ATOMS=2, OUT_ATOMS=4)
REQ-030 SHALL verify: 4 beats mask 2'b11, data 0x0100, 0x0302, 0x0504, 0x0706 -> out 0x03020100 mask f, then 0x07060504 mask f, out_end=0.
REQ-031 SHALL verify: masks 01, 11, 11 with A0; B1B0; C1C0 -> out {C0,B1,B0,A0} mask f; C1 retained, cnt=1.
REQ-032 SHALL verify: cnt=3 then mask 11 + inp_end -> full beat end=0, next cycle inp_prdy=0, then remainder mask 4'b0001 end=1.
REQ-033 SHALL verify: out_prdy=0 for 5 cycles while out_pvld=1 -> out stable, inp_prdy=0, no beat lost after release.
REQ-034 SHALL verify: reset asserted at cnt=2 -> next cycle out_pvld=0, cnt=0; next beat lands in lane 0.
REQ-035 SHALL verify: cnt=0, mask 00 + inp_end -> out_mask=0, out_end=1, one beat.

Source files
------------

// File: rtl/nv_nvdla_sdp_rdma_unpack_pkg.sv
// Shared definitions for the SDP RDMA unpacker.
//
// Contents:
//   ATOM_W_DEFAULT   default atom width in bits
//   MAX_ATOMS        widest mask the helper functions handle
//   state_e          unpacker control states (ACC, FLUSH)
//   popcount()       number of set bits in a mask
//   thermometer()    LSB-contiguous mask with n ones
package nv_nvdla_sdp_rdma_unpack_pkg;

  localparam int ATOM_W_DEFAULT = 256;

  // The helpers take fixed-width vectors. Atom counts per beat are
  // small, so 64 lanes leaves plenty of room for any configuration.
  localparam int MAX_ATOMS = 64;

  typedef enum logic {
    ST_ACC   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  function automatic int popcount(input logic [MAX_ATOMS-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < MAX_ATOMS; i++) begin
      if (v[i]) r = r + 1;
    end
    return r;
  endfunction

  function automatic logic [MAX_ATOMS-1:0] thermometer(input int n);
    logic [MAX_ATOMS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_ATOMS; i++) begin
      if (i < n) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nv_nvdla_sdp_rdma_atom_place.sv
// Combinational atom placement for the SDP RDMA unpacker.
//
// The input beat is laid out directly after the cnt atoms already held in
// the accumulator. This gives a combined lane array 2*OUT_ATOMS wide. The
// low OUT_ATOMS lanes form the candidate output or accumulator image. The
// upper lanes hold whatever spills past a full output beat, already moved
// down to lane 0.
//
// Ports:
//   cnt       atoms currently held in the accumulator (0..OUT_ATOMS-1)
//   acc_data  accumulator contents, lane 0 in the LSBs
//   inp_data  incoming beat; lanes at or above popcount(mask) are junk
//   out_low   combined lanes 0..OUT_ATOMS-1
//   out_rem   combined lanes OUT_ATOMS..2*OUT_ATOMS-1, shifted to lane 0
module nv_nvdla_sdp_rdma_atom_place
  import nv_nvdla_sdp_rdma_unpack_pkg::*;
#(
  parameter int ATOM_W    = ATOM_W_DEFAULT,
  parameter int IN_ATOMS  = 1,
  parameter int OUT_ATOMS = 4
) (
  input  logic [$clog2(OUT_ATOMS):0]     cnt,
  input  logic [OUT_ATOMS*ATOM_W-1:0]    acc_data,
  input  logic [IN_ATOMS*ATOM_W-1:0]     inp_data,
  output logic [OUT_ATOMS*ATOM_W-1:0]    out_low,
  output logic [OUT_ATOMS*ATOM_W-1:0]    out_rem
);

  localparam int LANES = 2 * OUT_ATOMS;
  localparam int LW    = $clog2(LANES);

  logic [ATOM_W-1:0] lane [LANES];

  // Build the combined lane image. Lanes below cnt come from the
  // accumulator. The next IN_ATOMS lanes take the input beat without
  // looking at the mask: lanes past the valid count are never counted
  // as valid downstream, so copying junk there is harmless.
  always_comb begin
    logic [LW-1:0] idx;
    idx = '0;
    for (int i = 0; i < LANES; i++) begin
      lane[i] = '0;
    end
    for (int i = 0; i < OUT_ATOMS; i++) begin
      if (i < int'(cnt)) lane[i] = acc_data[i*ATOM_W +: ATOM_W];
    end
    for (int k = 0; k < IN_ATOMS; k++) begin
      if (int'(cnt) + k < LANES) begin
        idx       = LW'(int'(cnt) + k);
        lane[idx] = inp_data[k*ATOM_W +: ATOM_W];
      end
    end
  end

  for (genvar g = 0; g < OUT_ATOMS; g++) begin : g_pack
    assign out_low[g*ATOM_W +: ATOM_W] = lane[g];
    assign out_rem[g*ATOM_W +: ATOM_W] = lane[OUT_ATOMS + g];
  end

endmodule

// File: rtl/nv_nvdla_sdp_rdma_unpack_n.sv
// SDP RDMA unpacker: packs narrow input beats of IN_ATOMS atoms into
// output beats of OUT_ATOMS atoms. Atoms are packed back to back with no
// beat alignment. A surface end (inp_end) flushes any partial beat with a
// thermometer mask.
//
// Ports:
//   nvdla_core_clk  clock
//   nvdla_core_rst  synchronous active-high reset
//   inp_pvld/prdy   input handshake
//   inp_data        IN_ATOMS atoms, lane 0 in the LSBs
//   inp_mask        valid atoms, LSB-contiguous
//   inp_end         last beat of the surface
//   out_pvld/prdy   output handshake (all outputs registered)
//   out_data        OUT_ATOMS atoms; lanes with mask bit 0 are don't-care
//   out_mask        valid atoms of the output beat
//   out_end         last output beat of the surface
module nv_nvdla_sdp_rdma_unpack_n
  import nv_nvdla_sdp_rdma_unpack_pkg::*;
#(
  parameter int ATOM_W    = ATOM_W_DEFAULT,
  parameter int IN_ATOMS  = 1,
  parameter int OUT_ATOMS = 4
) (
  input  logic                          nvdla_core_clk,
  input  logic                          nvdla_core_rst,
  input  logic                          inp_pvld,
  output logic                          inp_prdy,
  input  logic [IN_ATOMS*ATOM_W-1:0]    inp_data,
  input  logic [IN_ATOMS-1:0]           inp_mask,
  input  logic                          inp_end,
  output logic                          out_pvld,
  input  logic                          out_prdy,
  output logic [OUT_ATOMS*ATOM_W-1:0]   out_data,
  output logic [OUT_ATOMS-1:0]          out_mask,
  output logic                          out_end
);

  localparam int CW = $clog2(OUT_ATOMS) + 1;

  state_e                        state, state_nxt;
  logic [CW-1:0]                 cnt, cnt_nxt;
  logic [OUT_ATOMS*ATOM_W-1:0]   acc_data, acc_nxt;
  logic                          out_pvld_nxt;
  logic [OUT_ATOMS*ATOM_W-1:0]   out_data_nxt;
  logic [OUT_ATOMS-1:0]          out_mask_nxt;
  logic                          out_end_nxt;

  logic [OUT_ATOMS*ATOM_W-1:0]   place_low;
  logic [OUT_ATOMS*ATOM_W-1:0]   place_rem;

  logic out_free;
  logic accept;
  int   n_atoms;
  int   total;

  // The output register can take a new beat when it is empty or is being
  // drained in this same cycle.
  assign out_free = !out_pvld || out_prdy;
  assign inp_prdy = (state == ST_ACC) && out_free;
  assign accept   = inp_pvld && inp_prdy;

  // A non-contiguous mask is still handled as popcount atoms from lane 0.
  assign n_atoms  = popcount(MAX_ATOMS'(inp_mask));
  assign total    = int'(cnt) + n_atoms;

  nv_nvdla_sdp_rdma_atom_place #(
    .ATOM_W    (ATOM_W),
    .IN_ATOMS  (IN_ATOMS),
    .OUT_ATOMS (OUT_ATOMS)
  ) u_place (
    .cnt      (cnt),
    .acc_data (acc_data),
    .inp_data (inp_data),
    .out_low  (place_low),
    .out_rem  (place_rem)
  );

  // Next-state logic. By default the output register only drops its valid
  // bit when it is accepted. Everything else holds, which keeps a stalled
  // output beat stable. A full beat always goes to the output and leaves
  // the spill in the accumulator. On a surface end, the spill either ends
  // up in a separate FLUSH beat or, when nothing spills, the end beat goes
  // out directly.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    acc_nxt      = acc_data;
    out_pvld_nxt = out_pvld && !out_prdy;
    out_data_nxt = out_data;
    out_mask_nxt = out_mask;
    out_end_nxt  = out_end;

    case (state)
      ST_ACC: begin
        if (accept) begin
          if (total >= OUT_ATOMS) begin
            out_pvld_nxt = 1'b1;
            out_data_nxt = place_low;
            out_mask_nxt = '1;
            acc_nxt      = place_rem;
            if (inp_end && (total > OUT_ATOMS)) begin
              out_end_nxt = 1'b0;
              cnt_nxt     = CW'(total - OUT_ATOMS);
              state_nxt   = ST_FLUSH;
            end else if (inp_end) begin
              out_end_nxt = 1'b1;
              cnt_nxt     = '0;
            end else begin
              out_end_nxt = 1'b0;
              cnt_nxt     = CW'(total - OUT_ATOMS);
            end
          end else if (inp_end) begin
            out_pvld_nxt = 1'b1;
            out_data_nxt = place_low;
            out_mask_nxt = OUT_ATOMS'(thermometer(total));
            out_end_nxt  = 1'b1;
            cnt_nxt      = '0;
          end else begin
            acc_nxt = place_low;
            cnt_nxt = CW'(total);
          end
        end
      end

      ST_FLUSH: begin
        if (out_free) begin
          out_pvld_nxt = 1'b1;
          out_data_nxt = acc_data;
          out_mask_nxt = OUT_ATOMS'(thermometer(int'(cnt)));
          out_end_nxt  = 1'b1;
          cnt_nxt      = '0;
          state_nxt    = ST_ACC;
        end
      end

      default: begin
        state_nxt = ST_ACC;
      end
    endcase
  end

  // Control state and output qualifiers. Reset drops any partial pack or
  // pending flush.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state    <= ST_ACC;
      cnt      <= '0;
      out_pvld <= 1'b0;
      out_mask <= '0;
      out_end  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      out_pvld <= out_pvld_nxt;
      out_mask <= out_mask_nxt;
      out_end  <= out_end_nxt;
    end
  end

  // Data registers carry no reset. Their content only matters under a
  // valid mask.
  always_ff @(posedge nvdla_core_clk) begin
    acc_data <= acc_nxt;
    out_data <= out_data_nxt;
  end

  // The upstream is expected to send LSB-contiguous masks.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rst && accept) begin
      assert (inp_mask == IN_ATOMS'(thermometer(n_atoms)));
    end
  end

endmodule

// File: tb/tb_nv_nvdla_sdp_rdma_unpack_n.sv
// Testbench for nv_nvdla_sdp_rdma_unpack_n with ATOM_W=8, IN_ATOMS=2,
// OUT_ATOMS=4. The bench has a table of directed cycles, hand-written
// corner sequences, and a random phase. The random phase checks the DUT
// against an atom-queue reference model.
module tb_nv_nvdla_sdp_rdma_unpack_n;

  localparam int AW = 8;
  localparam int IA = 2;
  localparam int OA = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              inp_pvld;
  logic              inp_prdy;
  logic [IA*AW-1:0]  inp_data;
  logic [IA-1:0]     inp_mask;
  logic              inp_end;
  logic              out_pvld;
  logic              out_prdy;
  logic [OA*AW-1:0]  out_data;
  logic [OA-1:0]     out_mask;
  logic              out_end;

  int total_cnt = 0;
  int pass_cnt  = 0;
  bit mon_en    = 1'b0;

  always #5 clk = ~clk;

  nv_nvdla_sdp_rdma_unpack_n #(
    .ATOM_W    (AW),
    .IN_ATOMS  (IA),
    .OUT_ATOMS (OA)
  ) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .inp_pvld       (inp_pvld),
    .inp_prdy       (inp_prdy),
    .inp_data       (inp_data),
    .inp_mask       (inp_mask),
    .inp_end        (inp_end),
    .out_pvld       (out_pvld),
    .out_prdy       (out_prdy),
    .out_data       (out_data),
    .out_mask       (out_mask),
    .out_end        (out_end)
  );

  // One directed cycle: inputs held for one clock edge, then the outputs
  // expected just after that edge.
  typedef struct {
    string       name;
    logic        rst;
    logic        pvld;
    logic [1:0]  mask;
    logic [15:0] data;
    logic        iend;
    logic        oprdy;
    logic        exp_pvld;
    logic [3:0]  exp_mask;
    logic [31:0] exp_data;
    logic        exp_end;
    logic        exp_prdy;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  m;
    logic        e;
  } beat_t;

  // Reference model state: atoms waiting to be packed, and beats the DUT
  // still owes on its output.
  logic [7:0] atoms [$];
  beat_t      expq  [$];
  beat_t      mon_beat;

  function automatic vec_t mkVec(string name, logic r, logic pv, logic [1:0] m,
                                 logic [15:0] d, logic e, logic op, logic xv,
                                 logic [3:0] xm, logic [31:0] xd, logic xe,
                                 logic xp);
    vec_t v;
    v.name = name; v.rst = r; v.pvld = pv; v.mask = m; v.data = d;
    v.iend = e; v.oprdy = op; v.exp_pvld = xv; v.exp_mask = xm;
    v.exp_data = xd; v.exp_end = xe; v.exp_prdy = xp;
    return v;
  endfunction

  function automatic logic [31:0] laneMask(logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < OA; i++) r[i*AW +: AW] = {AW{m[i]}};
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic checkOutput(vec_t v);
    check({v.name, "_pvld"}, 32'(out_pvld), 32'(v.exp_pvld));
    if (v.exp_pvld) begin
      check({v.name, "_mask"}, 32'(out_mask), 32'(v.exp_mask));
      check({v.name, "_end"},  32'(out_end),  32'(v.exp_end));
      check({v.name, "_data"}, out_data & laneMask(v.exp_mask),
            v.exp_data & laneMask(v.exp_mask));
    end
    if (v.rst) begin
      check({v.name, "_rmask"}, 32'(out_mask), 32'd0);
      check({v.name, "_rend"},  32'(out_end),  32'd0);
    end
    check({v.name, "_iprdy"}, 32'(inp_prdy), 32'(v.exp_prdy));
  endtask

  task automatic applyStimulus(vec_t v);
    rst      = v.rst;
    inp_pvld = v.pvld;
    inp_mask = v.mask;
    inp_data = v.data;
    inp_end  = v.iend;
    out_prdy = v.oprdy;
    @(posedge clk);
    #1;
    checkOutput(v);
  endtask

  // Reference model: the atoms of each accepted beat join one stream.
  // Every four atoms make a full beat. A surface end emits what is left,
  // unless the full beat just taken already consumed everything.
  task automatic modelAccept(logic [1:0] m, logic [15:0] d, logic e);
    beat_t b;
    int    n;
    bit    ended;
    n     = 0;
    ended = 1'b0;
    for (int i = 0; i < IA; i++) if (m[i]) n++;
    for (int k = 0; k < n; k++) atoms.push_back(d[k*AW +: AW]);
    while (atoms.size() >= OA) begin
      b.d = {atoms[3], atoms[2], atoms[1], atoms[0]};
      for (int k = 0; k < OA; k++) void'(atoms.pop_front());
      b.m = 4'hf;
      b.e = e && (atoms.size() == 0);
      if (b.e) ended = 1'b1;
      expq.push_back(b);
    end
    if (e && !ended) begin
      b.d = '0;
      b.m = '0;
      for (int k = 0; k < atoms.size(); k++) begin
        b.d[k*AW +: AW] = atoms[k];
        b.m[k]          = 1'b1;
      end
      b.e = 1'b1;
      atoms.delete();
      expq.push_back(b);
    end
  endtask

  // Random-phase monitor. It samples at the falling edge, so the
  // handshakes seen here complete at the next rising edge.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (out_pvld && out_prdy) begin
        if (expq.size() == 0) begin
          check("rand_extra_beat", 32'd1, 32'd0);
        end else begin
          mon_beat = expq.pop_front();
          check("rand_mask", 32'(out_mask), 32'(mon_beat.m));
          check("rand_end",  32'(out_end),  32'(mon_beat.e));
          check("rand_data", out_data & laneMask(mon_beat.m),
                mon_beat.d & laneMask(mon_beat.m));
        end
      end
      if (inp_pvld && inp_prdy) modelAccept(inp_mask, inp_data, inp_end);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl [$];
    vec_t v;

    rst = 1'b1; inp_pvld = 1'b0; inp_mask = '0; inp_data = '0;
    inp_end = 1'b0; out_prdy = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: reset, aligned packing, unaligned packing, end
    // with an empty beat, and an exact-fit end.
    tbl.push_back(mkVec("rst0",      1,0,2'b00,16'h0000,0,1, 0,4'h0,32'h0,0,1));
    tbl.push_back(mkVec("rst_rel",   0,0,2'b00,16'h0000,0,1, 0,4'h0,32'h0,0,1));
    tbl.push_back(mkVec("seq_a0",    0,1,2'b11,16'h0100,0,1, 0,4'h0,32'h0,0,1));
    tbl.push_back(mkVec("seq_a1",    0,1,2'b11,16'h0302,0,1, 1,4'hf,32'h03020100,0,1));
    tbl.push_back(mkVec("seq_a2",    0,1,2'b11,16'h0504,0,1, 0,4'h0,32'h0,0,1));
    tbl.push_back(mkVec("seq_a3",    0,1,2'b11,16'h0706,0,1, 1,4'hf,32'h07060504,0,1));
    tbl.push_back(mkVec("mix_a",     0,1,2'b01,16'h55a0,0,1, 0,4'h0,32'h0,0,1));
    tbl.push_back(mkVec("mix_b",     0,1,2'b11,16'hb1b0,0,1, 0,4'h0,32'h0,0,1));
    tbl.push_back(mkVec("mix_c",     0,1,2'b11,16'hc1c0,0,1, 1,4'hf,32'hc0b1b0a0,0,1));
    tbl.push_back(mkVec("mix_tail",  0,1,2'b00,16'h0000,1,1, 1,4'h1,32'h000000c1,1,1));
    tbl.push_back(mkVec("empty_end", 0,1,2'b00,16'h0000,1,1, 1,4'h0,32'h0,1,1));
    tbl.push_back(mkVec("idle0",     0,0,2'b00,16'h0000,0,1, 0,4'h0,32'h0,0,1));
    tbl.push_back(mkVec("exact_a",   0,1,2'b11,16'h1211,0,1, 0,4'h0,32'h0,0,1));
    tbl.push_back(mkVec("exact_b",   0,1,2'b11,16'h1413,1,1, 1,4'hf,32'h14131211,1,1));
    tbl.push_back(mkVec("exact_idle",0,0,2'b00,16'h0000,0,1, 0,4'h0,32'h0,0,1));
    foreach (tbl[i]) applyStimulus(tbl[i]);

    // End with a spill: full beat first, input blocked during FLUSH, then
    // the one-atom remainder.
    applyStimulus(mkVec("fl_a",   0,1,2'b11,16'h2221,0,1, 0,4'h0,32'h0,0,1));
    applyStimulus(mkVec("fl_b",   0,1,2'b01,16'h0023,0,1, 0,4'h0,32'h0,0,1));
    applyStimulus(mkVec("fl_c",   0,1,2'b11,16'h2524,1,1, 1,4'hf,32'h24232221,0,0));
    applyStimulus(mkVec("fl_d",   0,0,2'b00,16'h0000,0,1, 1,4'h1,32'h00000025,1,1));
    applyStimulus(mkVec("fl_idle",0,0,2'b00,16'h0000,0,1, 0,4'h0,32'h0,0,1));

    // Output stall: the held beat stays put and the pending input beat
    // is not lost.
    applyStimulus(mkVec("st_a",   0,1,2'b11,16'h3231,0,1, 0,4'h0,32'h0,0,1));
    applyStimulus(mkVec("st_b",   0,1,2'b11,16'h3433,0,1, 1,4'hf,32'h34333231,0,1));
    for (int i = 0; i < 5; i++)
      applyStimulus(mkVec("st_hold",0,1,2'b11,16'h3635,0,0, 1,4'hf,32'h34333231,0,0));
    applyStimulus(mkVec("st_rel", 0,1,2'b11,16'h3635,0,1, 0,4'h0,32'h0,0,1));
    applyStimulus(mkVec("st_next",0,1,2'b11,16'h3837,0,1, 1,4'hf,32'h38373635,0,1));

    // Reset in the middle of a partial pack drops it.
    applyStimulus(mkVec("rs_a",   0,1,2'b11,16'h4241,0,1, 0,4'h0,32'h0,0,1));
    applyStimulus(mkVec("rs_rst", 1,0,2'b00,16'h0000,0,1, 0,4'h0,32'h0,0,1));
    applyStimulus(mkVec("rs_b",   0,1,2'b11,16'h4443,0,1, 0,4'h0,32'h0,0,1));
    applyStimulus(mkVec("rs_c",   0,1,2'b11,16'h4645,0,1, 1,4'hf,32'h46454443,0,1));

    // Reset while a FLUSH is pending drops the remainder.
    applyStimulus(mkVec("rf_a",   0,1,2'b11,16'h5251,0,1, 0,4'h0,32'h0,0,1));
    applyStimulus(mkVec("rf_b",   0,1,2'b01,16'h0053,0,1, 0,4'h0,32'h0,0,1));
    applyStimulus(mkVec("rf_c",   0,1,2'b11,16'h5554,1,1, 1,4'hf,32'h54535251,0,0));
    applyStimulus(mkVec("rf_rst", 1,0,2'b00,16'h0000,0,1, 0,4'h0,32'h0,0,1));
    applyStimulus(mkVec("rf_d",   0,1,2'b11,16'h5756,0,1, 0,4'h0,32'h0,0,1));
    applyStimulus(mkVec("rf_e",   0,1,2'b11,16'h5958,0,1, 1,4'hf,32'h59585756,0,1));

    // Random traffic against the reference model.
    rst = 1'b1; inp_pvld = 1'b0; out_prdy = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    atoms.delete();
    expq.delete();
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      int r;
      r        = int'($urandom_range(0, 4));
      inp_pvld = ($urandom_range(0, 3) != 0);
      inp_mask = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
      inp_data = 16'($urandom);
      inp_end  = ($urandom_range(0, 7) == 0);
      out_prdy = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    inp_pvld = 1'b0;
    out_prdy = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    mon_en = 1'b0;
    check("rand_drain", 32'(expq.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
